muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, serving MULT, MULTU, DIV and DIVU on behalf of the execute stage. It sits beside the combinational ALU, shares its operand buses (`src1`, `src2`), and writes the HI/LO register pair consumed by MFHI/MFLO. Operations take multiple cycles and use a start/busy/done handshake so the controller can stall until the result is valid.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_unit_div_step.sv | 45 ++++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared types and constants for the iterative multiply/divide unit.
//
// Contents:
//   MULDIV_WIDTH    default operand width (HI and LO are each this wide)
//   muldiv_op_t     encoding of the 2-bit 'control' op select
//   muldiv_state_t  sequencer states of muldiv_unit
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step -- one combinational restoring-divide step.
//
// The partial remainder is shifted left by one, pulling in the next dividend
// bit from the top of the quotient register. The divisor is then trial-subtracted.
// If the subtraction does not borrow, the difference is kept and a 1 is shifted
// into the quotient. Otherwise the shifted remainder is restored and a 0 is
// shifted in.
//
// Ports:
//   rem_in   [WIDTH]  partial remainder before the step
//   quo_in   [WIDTH]  quotient / remaining dividend bits before the step
//   divisor  [WIDTH]  unsigned divisor
//   rem_out  [WIDTH]  partial remainder after the step
//   quo_out  [WIDTH]  quotient / remaining dividend bits after the step
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor holds on every step, so the shifted value is below
  // 2*divisor. Bit WIDTH of the difference is therefore exactly the borrow.
  // With a zero divisor the remainder only collects dividend bits and stays
  // below 2^WIDTH, so no borrow ever occurs.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_out = shifted[WIDTH-1:0];
    end else begin
      rem_out = diff[WIDTH-1:0];
    end
    quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative MULT/MULTU/DIV/DIVU unit writing the HI/LO pair.
//
// The unit computes on operand magnitudes. It performs WIDTH radix-2 steps and
// then applies the sign fix-up when it writes HI/LO. Multiply and divide share
// one 2*WIDTH accumulator:
//   multiply: {partial product high, multiplier shifting out}
//   divide:   {partial remainder,   dividend in / quotient out}
//
// Optional feature: when MULDIV_FAST_MUL_EN is defined, MULT/MULTU are produced
// by a single-cycle combinational multiplier and skip RUN.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request pulse, sampled only in IDLE
//   control   op select (muldiv_op_t)
//   src1      multiplicand / dividend
//   src2      multiplier / divisor
//   busy      operation in progress (registered)
//   done      one-cycle pulse when hi/lo are written (registered)
//   div_zero  sticky: the last completed op was a divide by zero
//   hi        upper product / remainder
//   lo        lower product / quotient
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  muldiv_state_t      state, state_next;
  muldiv_op_t         op, op_in;
  logic               is_div, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, opnd;
  logic               sign_lo, sign_hi, dz;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mul_next, prod;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   rem_nx, quo_nx, hi_res, lo_res;

  // Operand capture: magnitudes plus the signs needed for the fix-up.
  always_comb begin
    op_in     = muldiv_op_t'(control);
    in_signed = (op_in == MULT) || (op_in == DIV);
    a_neg     = in_signed & src1[WIDTH-1];
    b_neg     = in_signed & src2[WIDTH-1];
    a_abs     = cneg(src1, a_neg);
    b_abs     = cneg(src2, b_neg);
    is_div    = (op == DIV) || (op == DIVU);
  end

  // Shift-add multiply step: the low bit of acc is the current multiplier bit.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc[2*WIDTH-1:WIDTH]),
    .quo_in  (acc[WIDTH-1:0]),
    .divisor (opnd),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_MUL_EN
          state_next = control[1] ? RUN : FINISH;
`else
          state_next = RUN;
`endif
        end
      end
      RUN:     if (cnt == LAST_STEP) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign fix-up. A divide by zero forces an all-ones quotient. Its remainder is
  // the dividend, recovered because the remainder collects every |src1| bit.
  always_comb begin
    prod = cneg_wide(acc, sign_lo);
    if (is_div) begin
      lo_res = dz ? '1 : cneg(acc[WIDTH-1:0], sign_lo);
      hi_res = cneg(acc[2*WIDTH-1:WIDTH], sign_hi);
    end else begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end
  end

  // Control and architectural outputs (reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state == FINISH);
      if (state == FINISH) begin
        hi       <= hi_res;
        lo       <= lo_res;
        div_zero <= dz;
      end
    end
  end

  // Datapath (no reset): only meaningful between a start and its FINISH.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op      <= op_in;
      sign_lo <= a_neg ^ b_neg;
      sign_hi <= a_neg;
      dz      <= control[1] && (src2 == '0);
      cnt     <= '0;
`ifdef MULDIV_FAST_MUL_EN
      if (!control[1]) begin
        acc  <= {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
        opnd <= a_abs;
      end else begin
        acc  <= {{WIDTH{1'b0}}, a_abs};
        opnd <= b_abs;
      end
`else
      if (control[1]) begin
        acc  <= {{WIDTH{1'b0}}, a_abs};
        opnd <= b_abs;
      end else begin
        acc  <= {{WIDTH{1'b0}}, b_abs};
        opnd <= a_abs;
      end
`endif
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
      acc <= is_div ? {rem_nx, quo_nx} : mul_next;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed self-checking bench for muldiv_unit.
// Behavioural model uses plain 64-bit arithmetic and per-op completion times.
// The model is compared against the DUT every negative clock edge. Each directed
// op also checks hand-computed literal results and latency.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  control = 2'b00;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .control  (control),
    .src1     (src1),
    .src2     (src2),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  int n_pass = 0;
  int n_total = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // Edges after the accepting edge until the one that raises done.
  function automatic int lat_of(input logic [1:0] c);
    return (FAST && !c[1]) ? 1 : 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural result of one op.
  task automatic model_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l, output logic z);
    longint      sa, sb, sp, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    case (c)
      2'b00: begin sp = sa * sb; {h, l} = sp; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      2'b10: begin
        if (b == 0) begin l = '1; h = a; z = 1'b1; end
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (b == 0) begin l = '1; h = a; z = 1'b1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  // Model state: at most one op in flight, completing at cycle 'due'.
  int          cyc = 0;
  int          due = 0;
  bit          pend = 1'b0;
  bit          was_pend;
  logic [31:0] p_hi, p_lo;
  logic        p_dz;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_dz = 1'b0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 1'b0; cyc = 0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_dz = 1'b0; exp_hi = '0; exp_lo = '0;
    end else begin
      cyc++;
      was_pend = pend;
      exp_done = 1'b0;
      if (pend && cyc == due) begin
        exp_hi = p_hi; exp_lo = p_lo; exp_dz = p_dz; exp_done = 1'b1; pend = 1'b0;
      end
      if (start && !was_pend) begin
        model_op(control, src1, src2, p_hi, p_lo, p_dz);
        due  = cyc + lat_of(control);
        pend = 1'b1;
      end
      exp_busy = pend;
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("cyc_done", {31'b0, done}, {31'b0, exp_done});
    chk("cyc_div_zero", {31'b0, div_zero}, {31'b0, exp_dz});
    chk("cyc_hi", hi, exp_hi);
    chk("cyc_lo", lo, exp_lo);
  end

  // Called at a negedge; returns at the negedge where done is seen, so an
  // immediately following call issues its start in the done cycle.
  task automatic do_op(input string name, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz);
    int  seen;
    bit  got;
    got = 1'b0; seen = 0;
    control = c; src1 = a; src2 = b; start = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 100; i++) begin
      src1    = $urandom;
      src2    = $urandom;
      control = 2'($urandom);
      start   = (i < lat_of(c)) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      if (done) begin got = 1'b1; seen = i; break; end
    end
    start = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL %s_timeout: no done within 100 cycles, expected %0d", name, lat_of(c));
    end else begin
      chk({name, "_lat"}, seen, (FAST && !c[1]) ? 1 : 33);
      chk({name, "_hi"}, hi, eh);
      chk({name, "_lo"}, lo, el);
      chk({name, "_dz"}, {31'b0, div_zero}, {31'b0, edz});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses;

  initial begin
    idle(3);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    idle(2);

    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    idle(1);
    do_op("mult_m7x3", 2'b00, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    do_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    idle(2);
    do_op("divu_100d0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1);
    do_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    idle(1);
    do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    do_op("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    do_op("div_m100d0", 2'b10, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1);
    do_op("multu_shift", 2'b01, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0);
    do_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    idle(2);

    // Abort a DIV with reset in its tenth cycle.
    control = 2'b10; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(9);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 32'd0);

    do_op("divu_after_rst", 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
